// File: rtl/vfp_switch_pkg.sv
// vfp_switch_pkg: register map, FSM states and response codes shared by the frame switch
package vfp_switch_pkg;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_LINES  = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_FRAMES = 8'h0C;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [15:0] LINES_RST = 16'd1080;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM} state_t;
endpackage

// File: rtl/vfp_axil_regs.sv
// vfp_axil_regs: AXI4-Lite slave holding CTRL/LINES/FRAMES and exposing STATUS
module vfp_axil_regs import vfp_switch_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [31:0]       status,
  input  logic              frame_inc,
  output logic              en,
  output logic [7:0]        sel,
  output logic [15:0]       lines
);
  logic [ADDR_W-1:0] wa, ra;
  logic [31:0] frames, rd;
  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0], WDATA[31:16], WSTRB[3:2]};
  assign wa = {AWADDR[ADDR_W-1:2], 2'b00};
  assign ra = {ARADDR[ADDR_W-1:2], 2'b00};
  assign WREADY = AWREADY;
  assign BRESP = RESP_OKAY;
  assign RRESP = RESP_OKAY;
  // SEL keeps a full byte so out-of-range selections read back exactly as written
  always_comb rd = (ra == ADDR_W'(REG_CTRL))   ? {16'b0, sel, 7'b0, en} :
                   (ra == ADDR_W'(REG_LINES))  ? {16'b0, lines} :
                   (ra == ADDR_W'(REG_STATUS)) ? status :
                   (ra == ADDR_W'(REG_FRAMES)) ? frames : 32'b0;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      AWREADY <= 1'b0;
      BVALID  <= 1'b0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= 32'b0;
      en      <= 1'b0;
      sel     <= 8'b0;
      lines   <= LINES_RST;
      frames  <= 32'b0;
    end else begin
      AWREADY <= !AWREADY && AWVALID && WVALID && !BVALID;
      ARREADY <= !ARREADY && ARVALID && !RVALID;
      if (AWREADY) BVALID <= 1'b1;
      else if (BREADY) BVALID <= 1'b0;
      if (ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= rd;
      end else if (RREADY) RVALID <= 1'b0;
      if (AWREADY && wa == ADDR_W'(REG_CTRL)) begin
        if (WSTRB[0]) en <= WDATA[0];
        if (WSTRB[1]) sel <= WDATA[15:8];
      end
      if (AWREADY && wa == ADDR_W'(REG_LINES)) begin
        if (WSTRB[0]) lines[7:0] <= WDATA[7:0];
        if (WSTRB[1]) lines[15:8] <= WDATA[15:8];
      end
      if (AWREADY && wa == ADDR_W'(REG_FRAMES)) frames <= 32'b0;
      else if (frame_inc) frames <= frames + 32'd1;
    end
  end
endmodule

// File: rtl/vfp_axis_frame_switch.sv
// vfp_axis_frame_switch: N-input AXI4-Stream video switch that changes source only at frame boundaries
module vfp_axis_frame_switch import vfp_switch_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 24,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int ADDR_W = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  input  logic [NUM_CH-1:0]        s_axis_tuser,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic [DATA_W-1:0]        m_axis_tdata
);
  state_t state;
  logic en, ok, in_v, in_l, in_u, out_free, fwd, take, eof, frame_inc;
  logic [7:0] sel, act;
  logic [15:0] lines, lines_eff, line_cnt, base, nxt;
  logic [SEL_W-1:0] a;
  logic [DATA_W-1:0] in_d;
  logic [31:0] status;
  assign a = act[SEL_W-1:0];
  assign ok = act < 8'(NUM_CH);
  assign in_v = s_axis_tvalid[a];
  assign in_l = s_axis_tlast[a];
  assign in_u = s_axis_tuser[a];
  assign in_d = s_axis_tdata[a*DATA_W +: DATA_W];
  assign out_free = !m_axis_tvalid || m_axis_tready;
  // In WAIT_SOF only the start-of-frame beat is held for the output; everything else drains
  assign fwd = ok && (state == STREAM || (state == WAIT_SOF && en && in_u));
  assign take = fwd && in_v && out_free;
  assign lines_eff = (lines == 16'd0) ? 16'd1 : lines;
  assign base = in_u ? 16'd0 : line_cnt;
  assign nxt = base + 16'(in_l);
  assign eof = in_l && nxt >= lines_eff;
  assign frame_inc = take && ((in_u && state == STREAM) || eof);
  assign status = {{(24-SEL_W){1'b0}}, a, 6'b0, sel != act, state != IDLE};
  always_comb begin
    s_axis_tready = {NUM_CH{ARESETN}};
    if (fwd && ARESETN) s_axis_tready[a] = out_free;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      act           <= 8'b0;
      line_cnt      <= 16'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (out_free) m_axis_tvalid <= take;
      if (take) begin
        m_axis_tdata <= in_d;
        m_axis_tlast <= in_l;
        m_axis_tuser <= in_u;
      end
      if (state == IDLE) begin
        if (en) begin
          act      <= sel;
          line_cnt <= 16'b0;
          state    <= WAIT_SOF;
        end
      end else if (state == WAIT_SOF && !en) state <= IDLE;
      else if (take) begin
        if (eof) begin
          line_cnt <= 16'b0;
          act      <= sel;
          state    <= en ? WAIT_SOF : IDLE;
        end else begin
          line_cnt <= nxt;
          state    <= STREAM;
        end
      end
    end
  end
  vfp_axil_regs #(.ADDR_W(ADDR_W)) u_regs (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .status(status), .frame_inc(frame_inc), .en(en), .sel(sel), .lines(lines)
  );
endmodule

// File: tb/tb_vfp_axis_frame_switch.sv
// tb_vfp_axis_frame_switch: directed frames on a 4-channel switch checked against an expected-beat scoreboard
module tb_vfp_axis_frame_switch;
  localparam int NC = 4;
  localparam int DW = 24;
  typedef struct packed {logic [23:0] d; logic l; logic u;} beat_t;
  logic ACLK = 0, ARESETN = 1;
  logic [7:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [NC-1:0] s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NC*DW-1:0] s_tdata;
  logic m_tvalid, m_tready, m_tlast, m_tuser;
  logic [DW-1:0] m_tdata;
  logic [25:0] cur_word, prev_word;
  logic prev_stall = 0;
  beat_t exp_q[$];
  logic [25:0] out_log[$];
  int checks = 0, errors = 0, out_users = 0, out_lasts = 0;
  int rdy_mode = 0;
  bit mon_on = 1;

  vfp_axis_frame_switch #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tdata(m_tdata)
  );

  assign cur_word = {m_tuser, m_tlast, m_tdata};
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge ACLK) begin
    #1;
    m_tready = (rdy_mode == 1) ? 1'($urandom % 2) : (rdy_mode == 0);
  end

  // Every accepted output beat must be the next one the scoreboard expects
  always @(negedge ACLK) begin
    if (mon_on && ARESETN) begin
      if (prev_stall) chk("stall_hold", {5'b0, m_tvalid, cur_word}, {5'b0, 1'b1, prev_word});
      if (m_tvalid && m_tready) begin
        out_log.push_back(cur_word);
        out_users += int'(m_tuser);
        out_lasts += int'(m_tlast);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got 0x%0h expected no beat", cur_word);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", {6'b0, cur_word}, {6'b0, e.u, e.l, e.d});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word = cur_word;
    end else prev_stall = 0;
  end

  task automatic send(input int ch, input logic [23:0] d, input logic l, input logic u);
    int n = 0;
    s_tvalid[ch] = 1;
    s_tdata[ch*DW +: DW] = d;
    s_tlast[ch] = l;
    s_tuser[ch] = u;
    forever begin
      @(negedge ACLK);
      if (s_tready[ch]) break;
      if (++n > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: ch%0d ready stayed 0, required 1", ch);
        break;
      end
    end
    @(posedge ACLK);
    #1;
    s_tvalid[ch] = 0;
    s_tlast[ch] = 0;
    s_tuser[ch] = 0;
  endtask

  task automatic frame(input int ch, input logic [7:0] tag, input int l0, input int nl, input bit sof, input bit expect_out);
    for (int ln = l0; ln < l0 + nl; ln++)
      for (int px = 0; px < 8; px++) begin
        beat_t b;
        b.d = {tag, 8'(ln), 8'(px)};
        b.l = (px == 7);
        b.u = sof && ln == l0 && px == 0;
        if (expect_out) exp_q.push_back(b);
        send(ch, b.d, b.l, b.u);
      end
  endtask

  task automatic axw(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    forever begin
      @(negedge ACLK);
      if (AWREADY) break;
      if (++n > 100) begin checks++; errors++; $display("FAIL awready_timeout: got 0 required 1"); break; end
    end
    @(posedge ACLK);
    #1;
    AWVALID = 0; WVALID = 0;
    n = 0;
    forever begin
      if (BVALID) break;
      @(negedge ACLK);
      if (++n > 100) begin checks++; errors++; $display("FAIL bvalid_timeout: got 0 required 1"); break; end
    end
    chk("bresp", {30'b0, BRESP}, 32'h0);
    @(posedge ACLK);
    #1;
  endtask

  task automatic axr(input logic [7:0] a, output logic [31:0] d);
    int n = 0;
    ARADDR = a; ARVALID = 1;
    d = 32'hDEAD_BEEF;
    forever begin
      @(negedge ACLK);
      if (ARREADY) break;
      if (++n > 100) begin checks++; errors++; $display("FAIL arready_timeout: got 0 required 1"); break; end
    end
    @(posedge ACLK);
    #1;
    ARVALID = 0;
    n = 0;
    forever begin
      @(negedge ACLK);
      if (RVALID) begin d = RDATA; break; end
      if (++n > 100) begin checks++; errors++; $display("FAIL rvalid_timeout: got 0 required 1"); break; end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int b0, u0, l0;
    AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 1;
    ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 1;
    s_tvalid = 0; s_tlast = 0; s_tuser = 0; s_tdata = 0; m_tready = 1;
    #1 ARESETN = 0;
    #11;
    chk("rst_m_tvalid", {31'b0, m_tvalid}, 0);
    chk("rst_s_tready", {28'b0, s_tready}, 0);
    chk("rst_awready", {31'b0, AWREADY}, 0);
    #10 ARESETN = 1;
    @(negedge ACLK);
    chk("idle_drain", {28'b0, s_tready}, 32'hF);
    axr(8'h04, r); chk("lines_default", r, 32'd1080);
    axr(8'h00, r); chk("ctrl_default", r, 0);
    axr(8'h08, r); chk("status_default", r, 0);
    axr(8'h0C, r); chk("frames_default", r, 0);
    axr(8'h20, r); chk("unmapped_read", r, 0);

    // basic 4x8 frame on ch2 after junk
    axw(8'h04, 32'd4, 4'hF);
    axw(8'h00, 32'h201, 4'hF);
    b0 = out_log.size(); u0 = out_users; l0 = out_lasts;
    for (int i = 0; i < 3; i++) send(2, 24'h0BAD00 + 24'(i), 0, 0);
    frame(2, 8'hA1, 0, 4, 1, 1);
    wait_empty();
    chk("t1_beats", out_log.size() - b0, 32);
    chk("t1_users", out_users - u0, 1);
    chk("t1_lasts", out_lasts - l0, 4);
    if (out_log.size() >= b0 + 32) begin
      chk("t1_first_word", {6'b0, out_log[b0]}, 32'h2A1_0000);
      chk("t1_line1_last", {6'b0, out_log[b0+15]}, 32'h1A1_0107);
      chk("t1_final_word", {6'b0, out_log[b0+31]}, 32'h1A1_0307);
    end
    axr(8'h0C, r); chk("t1_frames", r, 1);
    axr(8'h08, r); chk("t1_status", r, 32'h201);

    // source change mid-frame only takes effect at frame end
    b0 = out_log.size(); u0 = out_users;
    frame(2, 8'hB2, 0, 2, 1, 1);
    axw(8'h00, 32'h101, 4'hF);
    axr(8'h08, r); chk("t2_pending", r, 32'h203);
    frame(2, 8'hB2, 2, 2, 0, 1);
    send(2, 24'hEEEE00, 0, 1);
    send(1, 24'hEEEE01, 0, 0);
    frame(1, 8'hC1, 0, 4, 1, 1);
    wait_empty();
    chk("t2_beats", out_log.size() - b0, 64);
    chk("t2_users", out_users - u0, 2);
    if (out_log.size() >= b0 + 33) chk("t2_ch1_sof", {6'b0, out_log[b0+32]}, 32'h2C1_0000);
    axr(8'h08, r); chk("t2_status", r, 32'h101);
    axr(8'h0C, r); chk("t2_frames", r, 3);
    axw(8'h0C, 32'h1234, 4'hF);
    axr(8'h0C, r); chk("frames_clear", r, 0);

    // random output backpressure with continuous input
    rdy_mode = 1;
    b0 = out_log.size();
    frame(1, 8'hD3, 0, 4, 1, 1);
    wait_empty();
    rdy_mode = 0;
    chk("t3_beats", out_log.size() - b0, 32);
    axw(8'h0C, 0, 4'hF);

    // early SOF after two lines
    b0 = out_log.size(); u0 = out_users;
    frame(1, 8'hE4, 0, 2, 1, 1);
    frame(1, 8'hE5, 0, 4, 1, 1);
    wait_empty();
    chk("t4_beats", out_log.size() - b0, 48);
    chk("t4_users", out_users - u0, 2);
    if (out_log.size() >= b0 + 17) chk("t4_new_sof", {6'b0, out_log[b0+16]}, 32'h2E5_0000);
    axr(8'h0C, r); chk("t4_frames", r, 2);

    // out-of-range select drains everything; byte strobes build CTRL
    axw(8'h00, 32'h0, 4'hF);
    axw(8'h00, 32'h0000_0700, 4'h2);
    axw(8'h00, 32'h0000_FF01, 4'h1);
    axr(8'h00, r); chk("t5_ctrl", r, 32'h701);
    b0 = out_log.size();
    @(negedge ACLK);
    chk("t5_drain", {28'b0, s_tready}, 32'hF);
    frame(3, 8'hF6, 0, 1, 1, 0);
    frame(0, 8'hF0, 0, 1, 1, 0);
    repeat (10) @(negedge ACLK);
    chk("t5_no_output", out_log.size() - b0, 0);
    axr(8'h08, r); chk("t5_busy", {31'b0, r[0]}, 1);

    // asynchronous reset in the middle of a stalled frame
    axw(8'h00, 32'h0, 4'hF);
    axw(8'h00, 32'h101, 4'hF);
    mon_on = 0;
    rdy_mode = 2;
    @(posedge ACLK);
    #2;
    send(1, 24'h123456, 0, 1);
    @(negedge ACLK);
    chk("t6_held_valid", {31'b0, m_tvalid}, 1);
    chk("t6_held_data", {8'b0, m_tdata}, 32'h123456);
    chk("t6_stalled_ready", {28'b0, s_tready}, 32'hD);
    #2 ARESETN = 0;
    #1;
    chk("t6_rst_tvalid", {31'b0, m_tvalid}, 0);
    chk("t6_rst_word", {6'b0, cur_word}, 0);
    chk("t6_rst_ready", {28'b0, s_tready}, 0);
    #9 ARESETN = 1;
    rdy_mode = 0;
    mon_on = 1;
    axr(8'h04, r); chk("t6_lines", r, 32'd1080);
    axr(8'h00, r); chk("t6_ctrl", r, 0);
    axr(8'h0C, r); chk("t6_frames", r, 0);
    axr(8'h08, r); chk("t6_status", r, 0);
    chk("t6_no_pending_beats", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
